// File: rtl/fifo_rd_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_rd_ctrl
//
// Read-side controller of the async FIFO. Owns the read binary/Gray pointers,
// computes empty against the write pointer already synchronised into rclk,
// drives the read port of the dual-port memory (synchronous read, 1-cycle
// latency) and presents a first-word-fall-through valid/ready stream through
// a 2-entry output buffer (output register + skid register).
//
// Ports:
//   rclk       in   read-domain clock
//   rrst_n     in   asynchronous active-low reset
//   rq2_wptr   in   write Gray pointer, synchronised into rclk
//   rptr       out  registered read Gray pointer, to the write-side synchroniser
//   raddr      out  memory read address (low bits of the binary read pointer)
//   rclken     out  memory read enable
//   rdata_mem  in   memory read data, valid the cycle after rclken
//   rempty     out  pointer-level empty flag
//   rvalid     out  rdata holds a valid word
//   rready     in   consumer accepts rdata when rvalid && rready
//   rdata      out  registered output word
// ----------------------------------------------------------------------------
module fifo_rd_ctrl #(
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic [ADDR_WIDTH:0]   rq2_wptr,
   output logic [ADDR_WIDTH:0]   rptr,
   output logic [ADDR_WIDTH-1:0] raddr,
   output logic                  rclken,
   input  logic [DATA_WIDTH-1:0] rdata_mem,
   output logic                  rempty,
   output logic                  rvalid,
   input  logic                  rready,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [ADDR_WIDTH:0]   rbin_q, rbin_d;
   logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  rd_pend_q;
   logic                  rvalid_q, rvalid_d;
   logic                  skid_valid_q, skid_valid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;

   logic pop;
   logic issue;

   // ---------------------------------------------------------------------
   // Pointer / issue logic
   // ---------------------------------------------------------------------
   always_comb begin
      rempty = (rptr_q == rq2_wptr);
      pop    = rvalid_q & rready;
      // cnt covers output reg + skid + in-flight read, so at most two words
      // may be outstanding; a same-cycle pop makes room for a new issue.
      // Gating with rrst_n keeps the memory idle while reset is held.
      issue  = rrst_n & ~rempty & ((cnt_q != 2'd2) | pop);
      rbin_d = rbin_q + {{ADDR_WIDTH{1'b0}}, issue};
      // Gray code taken from the registered next value: a single bit toggles
      // per increment and nothing combinational reaches the write domain.
      rptr_d = rbin_d ^ (rbin_d >> 1);
      cnt_d  = cnt_q + {1'b0, issue} - {1'b0, pop};
   end

   assign rclken = issue;
   assign raddr  = rbin_q[ADDR_WIDTH-1:0];
   assign rptr   = rptr_q;

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rbin_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= 2'd0;
         rd_pend_q <= 1'b0;
      end else begin
         rbin_q    <= rbin_d;
         rptr_q    <= rptr_d;
         cnt_q     <= cnt_d;
         rd_pend_q <= issue;
      end
   end

   // ---------------------------------------------------------------------
   // Output register + skid buffer
   // ---------------------------------------------------------------------
   always_comb begin
      rvalid_d     = rvalid_q;
      skid_valid_d = skid_valid_q;
      rdata_d      = rdata_q;
      skid_d       = skid_q;

      if (rd_pend_q) begin
         if (skid_valid_q) begin
            // Skid full plus a read landing implies three words, which the
            // issue limit forbids unless a pop frees the output register.
            if (pop) begin
               rdata_d = skid_q;
               skid_d  = rdata_mem;
            end
         end else if (!rvalid_q || pop) begin
            rdata_d  = rdata_mem;
            rvalid_d = 1'b1;
         end else begin
            skid_d       = rdata_mem;
            skid_valid_d = 1'b1;
         end
      end else if (pop) begin
         if (skid_valid_q) begin
            rdata_d      = skid_q;
            skid_valid_d = 1'b0;
         end else begin
            rvalid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rvalid_q     <= 1'b0;
         skid_valid_q <= 1'b0;
         rdata_q      <= '0;
         skid_q       <= '0;
      end else begin
         rvalid_q     <= rvalid_d;
         skid_valid_q <= skid_valid_d;
         rdata_q      <= rdata_d;
         skid_q       <= skid_d;
      end
   end

   assign rvalid = rvalid_q;
   assign rdata  = rdata_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//
// Bench for the FIFO read-side controller. A behavioural memory and writer
// feed the DUT; written words go into a scoreboard queue and are compared as
// the consumer pops them. A per-cycle vector table covers reset/idle and the
// single-word latency; directed sequences cover backpressure, wrap and reset.
// ----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

   localparam int AW = 3;
   localparam int DW = 8;

   logic          rclk = 1'b0;
   logic          rrst_n = 1'b0;
   logic [AW:0]   rq2_wptr;
   logic [AW:0]   rptr;
   logic [AW-1:0] raddr;
   logic          rclken;
   logic [DW-1:0] rdata_mem = '0;
   logic          rempty;
   logic          rvalid;
   logic          rready = 1'b0;
   logic [DW-1:0] rdata;

   fifo_rd_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .rclk      (rclk),
      .rrst_n    (rrst_n),
      .rq2_wptr  (rq2_wptr),
      .rptr      (rptr),
      .raddr     (raddr),
      .rclken    (rclken),
      .rdata_mem (rdata_mem),
      .rempty    (rempty),
      .rvalid    (rvalid),
      .rready    (rready),
      .rdata     (rdata)
   );

   always #5 rclk = ~rclk;

   function automatic logic [AW:0] gray(input logic [AW:0] b);
      return b ^ (b >> 1);
   endfunction

   // Behavioural memory and writer
   logic [DW-1:0] mem [8];
   logic [AW:0]   wbin = '0;
   assign rq2_wptr = gray(wbin);

   always @(posedge rclk) if (rclken) rdata_mem <= mem[raddr];

   int n_vec = 0;
   int n_err = 0;
   int written, popped, issued;
   bit mon_en = 1'b0;
   logic          hold_prev;
   logic [DW-1:0] data_prev;
   logic [AW:0]   rptr_prev;
   logic [DW-1:0] sb [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_word(input logic [DW-1:0] d);
      mem[wbin[AW-1:0]] = d;
      wbin = wbin + 1'b1;
      written++;
      sb.push_back(d);
   endtask

   // Sample 1 time unit after the falling edge, run the monitor, wait for
   // the next falling edge (inputs are driven there).
   task automatic tick();
      logic [DW-1:0] exp_d;
      #1;
      if (mon_en) begin
         if (rclken) begin
            check("raddr_seq", 32'(raddr), 32'(issued % 8));
            issued++;
            check("issue_le_written", 32'(issued <= written), 32'd1);
         end
         if (hold_prev) begin
            check("hold_valid", 32'(rvalid), 32'd1);
            check("hold_data", 32'(rdata), 32'(data_prev));
         end
         check("rptr_onebit", 32'($countones(rptr ^ rptr_prev) <= 1), 32'd1);
         if (rvalid && rready) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL pop_unexpected: got word %0h, expected no word", rdata);
            end else begin
               exp_d = sb.pop_front();
               check("pop_data", 32'(rdata), 32'(exp_d));
               popped++;
            end
         end
      end
      hold_prev = rvalid && !rready;
      data_prev = rdata;
      rptr_prev = rptr;
      @(negedge rclk);
   endtask

   task automatic do_reset();
      rrst_n  = 1'b0;
      wbin    = '0;
      written = 0;
      popped  = 0;
      issued  = 0;
      sb.delete();
      repeat (2) @(negedge rclk);
      rrst_n    = 1'b1;
      hold_prev = 1'b0;
      rptr_prev = '0;
   endtask

   typedef struct packed {
      logic          rdy;
      logic [AW:0]   wb;
      logic          empty;
      logic          clken;
      logic [AW-1:0] addr;
      logic          valid;
      logic [DW-1:0] data;
      logic [AW:0]   ptr;
   } vec_t;

   vec_t tbl [8];

   initial begin
      // rdy, wbin, empty, clken, raddr, valid, rdata, rptr
      tbl[0] = '{1'b1, 4'd0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'b0000};
      tbl[1] = '{1'b1, 4'd0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'b0000};
      tbl[2] = '{1'b1, 4'd0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'b0000};
      tbl[3] = '{1'b1, 4'd1, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 4'b0000};
      tbl[4] = '{1'b1, 4'd1, 1'b1, 1'b0, 3'd1, 1'b0, 8'h00, 4'b0001};
      tbl[5] = '{1'b1, 4'd1, 1'b1, 1'b0, 3'd1, 1'b1, 8'hA5, 4'b0001};
      tbl[6] = '{1'b1, 4'd1, 1'b1, 1'b0, 3'd1, 1'b0, 8'hA5, 4'b0001};
      tbl[7] = '{1'b1, 4'd1, 1'b1, 1'b0, 3'd1, 1'b0, 8'hA5, 4'b0001};

      for (int i = 0; i < 8; i++) mem[i] = '0;
      @(negedge rclk);

      // ---- Table: reset/idle, then one word with FWFT latency ----
      do_reset();
      mem[0] = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         rready = tbl[i].rdy;
         wbin   = tbl[i].wb;
         #1;
         check("tbl_rempty", 32'(rempty), 32'(tbl[i].empty));
         check("tbl_rclken", 32'(rclken), 32'(tbl[i].clken));
         check("tbl_raddr",  32'(raddr),  32'(tbl[i].addr));
         check("tbl_rvalid", 32'(rvalid), 32'(tbl[i].valid));
         check("tbl_rdata",  32'(rdata),  32'(tbl[i].data));
         check("tbl_rptr",   32'(rptr),   32'(tbl[i].ptr));
         @(negedge rclk);
      end

      // ---- Eight words under backpressure, then a full-rate drain ----
      do_reset();
      mon_en = 1'b1;
      rready = 1'b0;
      for (int i = 0; i < 8; i++) push_word(8'h10 + 8'(i));
      repeat (6) tick();
      check("bp_issues", 32'(issued), 32'd2);
      check("bp_rvalid", 32'(rvalid), 32'd1);
      check("bp_rdata", 32'(rdata), 32'h10);
      rready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         check("drain_no_gap", 32'(rvalid), 32'd1);
         tick();
      end
      tick();
      check("drain_popped", 32'(popped), 32'd8);
      check("drain_rvalid_low", 32'(rvalid), 32'd0);
      check("drain_rptr", 32'(rptr), 32'b1100);
      check("drain_rempty", 32'(rempty), 32'd1);

      // ---- Streaming 20 words across wrap, random backpressure ----
      do_reset();
      for (int cyc = 0; cyc < 500 && popped < 20; cyc++) begin
         if (written < 20 && (written - popped) < 8) push_word(8'($urandom_range(0, 255)));
         rready = 1'($urandom_range(0, 1));
         tick();
      end
      rready = 1'b0;
      tick();
      check("stream_popped", 32'(popped), 32'd20);
      check("stream_sb_empty", 32'(sb.size()), 32'd0);
      check("stream_issued", 32'(issued), 32'd20);
      check("stream_rptr", 32'(rptr), 32'(gray(4'd4)));

      // ---- Reset while two words are outstanding and a read is in flight ----
      do_reset();
      rready = 1'b0;
      for (int i = 0; i < 8; i++) push_word(8'h30 + 8'(i));
      tick();
      tick();
      rrst_n = 1'b0;
      #1;
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_rptr", 32'(rptr), 32'd0);
      check("rst_raddr", 32'(raddr), 32'd0);
      check("rst_rclken", 32'(rclken), 32'd0);
      do_reset();
      rready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("post_rst_idle", 32'(rvalid), 32'd0);
         tick();
      end
      push_word(8'h5A);
      repeat (4) tick();
      check("post_rst_first", 32'(popped), 32'd1);
      check("post_rst_rptr", 32'(rptr), 32'b0001);
      mon_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
